mem_responder: RTL and testbench

- Memory-side responder for the cluster's outbound L2 memory bus: the slave end of the channel the cluster drives as master.
- Accepts line-granular read and write requests and commits writes to an internal line RAM with byte enables.
- Returns read data in request order after a fixed latency, with a tag echo.
- Used as the memory model below a cluster in sim/FPGA bring-up; flow control is credit-based so responses are never dropped.

---
 rtl/mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_mem_responder.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Slave end of the L2 memory bus: byte-enabled line RAM, fixed-latency in-order read responses, credit flow control.
// Define MEM_RESPONDER_PERF_EN to add the perf_reads / perf_writes / perf_stalls counters.
module mem_responder #(
  parameter int LINE_SIZE      = 64,
  parameter int ADDR_WIDTH     = 26,
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int TAG_WIDTH      = 8,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_req_valid,
  input  logic                      mem_req_rw,
  input  logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic [LINE_SIZE-1:0]      mem_req_byteen,
  input  logic [LINE_SIZE*8-1:0]    mem_req_data,
  input  logic [TAG_WIDTH-1:0]      mem_req_tag,
  output logic                      mem_req_ready,
  output logic                      mem_rsp_valid,
  output logic [LINE_SIZE*8-1:0]    mem_rsp_data,
  output logic [TAG_WIDTH-1:0]      mem_rsp_tag,
  input  logic                      mem_rsp_ready,
  output logic                      busy
`ifdef MEM_RESPONDER_PERF_EN
  ,
  output logic [31:0]               perf_reads,
  output logic [31:0]               perf_writes,
  output logic [31:0]               perf_stalls
`endif
);

  localparam int DATA_WIDTH = LINE_SIZE * 8;
  localparam int RAM_DEPTH  = 1 << RAM_ADDR_WIDTH;
  localparam int IDX_W      = $clog2(RSP_QUEUE);
  localparam int PTR_W      = IDX_W + 1;
  localparam int CNT_W      = $clog2(RSP_QUEUE + 1);

  if (LATENCY < 1 || RSP_QUEUE < 2 || RSP_QUEUE < LATENCY ||
      (RSP_QUEUE & (RSP_QUEUE - 1)) != 0) begin : g_param_check
    $error("mem_responder: RSP_QUEUE must be a power of two, >= 2 and >= LATENCY >= 1");
  end

  logic [LINE_SIZE-1:0][7:0]  ram_mem [RAM_DEPTH];
  logic [RAM_ADDR_WIDTH-1:0]  ram_addr;
  logic                       ready_en_reg;
  logic [CNT_W-1:0]           credit_reg;
  logic [CNT_W-1:0]           credit_next;
  logic                       req_accept;
  logic                       rd_accept;
  logic                       wr_accept;
  logic                       rsp_pop;
  logic                       push_valid;
  logic [TAG_WIDTH-1:0]       push_tag;
  logic [DATA_WIDTH-1:0]      push_data;
  logic [DATA_WIDTH-1:0]      fifo_data [RSP_QUEUE];
  logic [TAG_WIDTH-1:0]       fifo_tag  [RSP_QUEUE];
  logic [PTR_W-1:0]           wr_ptr_reg;
  logic [PTR_W-1:0]           rd_ptr_reg;
  logic                       fifo_empty;
  logic                       fifo_full;

  // Upper address bits alias onto the RAM and are deliberately ignored.
  assign ram_addr = mem_req_addr[RAM_ADDR_WIDTH-1:0];
  if (ADDR_WIDTH > RAM_ADDR_WIDTH) begin : g_alias
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_req_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];
  end

  // ready_en_reg holds ready low for the first cycle after reset releases.
  assign mem_req_ready = ready_en_reg && reset && (credit_reg < CNT_W'(RSP_QUEUE));
  assign req_accept    = mem_req_valid && mem_req_ready;
  assign rd_accept     = req_accept && !mem_req_rw;
  assign wr_accept     = req_accept && mem_req_rw;
  assign rsp_pop       = mem_rsp_valid && mem_rsp_ready;
  assign busy          = (credit_reg != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_en_reg <= 1'b0;
      credit_reg   <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      credit_reg   <= credit_next;
    end
  end

  always_comb begin
    credit_next = credit_reg;
    if (rd_accept && !rsp_pop) begin
      credit_next = credit_reg + CNT_W'(1);
    end else if (!rd_accept && rsp_pop) begin
      credit_next = credit_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int b = 0; b < LINE_SIZE; b++) begin
        if (mem_req_byteen[b]) begin
          ram_mem[ram_addr][b] <= mem_req_data[b*8 +: 8];
        end
      end
    end
  end

  // The RAM read register is stage 0; LATENCY-1 register hops later the entry lands in the FIFO.
  if (LATENCY == 1) begin : g_direct
    assign push_valid = rd_accept;
    assign push_tag   = mem_req_tag;
    assign push_data  = ram_mem[ram_addr];
  end else begin : g_pipe
    logic [LATENCY-2:0]     valid_reg;
    logic [TAG_WIDTH-1:0]   tag_reg  [LATENCY-1];
    logic [DATA_WIDTH-1:0]  data_reg [LATENCY-1];

    always_ff @(posedge clk) begin
      if (!reset) begin
        valid_reg <= '0;
      end else begin
        valid_reg[0] <= rd_accept;
        for (int s = 1; s < LATENCY - 1; s++) begin
          valid_reg[s] <= valid_reg[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      data_reg[0] <= ram_mem[ram_addr];
      tag_reg[0]  <= mem_req_tag;
      for (int s = 1; s < LATENCY - 1; s++) begin
        data_reg[s] <= data_reg[s-1];
        tag_reg[s]  <= tag_reg[s-1];
      end
    end

    assign push_valid = valid_reg[LATENCY-2];
    assign push_tag   = tag_reg[LATENCY-2];
    assign push_data  = data_reg[LATENCY-2];
  end

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                      (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_valid) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rsp_pop)    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_valid) begin
      fifo_data[wr_ptr_reg[IDX_W-1:0]] <= push_data;
      fifo_tag[wr_ptr_reg[IDX_W-1:0]]  <= push_tag;
    end
  end

  assign mem_rsp_valid = !fifo_empty;
  assign mem_rsp_data  = fifo_data[rd_ptr_reg[IDX_W-1:0]];
  assign mem_rsp_tag   = fifo_tag[rd_ptr_reg[IDX_W-1:0]];

`ifdef MEM_RESPONDER_PERF_EN
  logic [31:0] perf_reads_reg;
  logic [31:0] perf_writes_reg;
  logic [31:0] perf_stalls_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_reads_reg  <= '0;
      perf_writes_reg <= '0;
      perf_stalls_reg <= '0;
    end else begin
      if (rd_accept) perf_reads_reg <= perf_reads_reg + 32'd1;
      if (wr_accept) perf_writes_reg <= perf_writes_reg + 32'd1;
      if (mem_req_valid && !mem_req_ready) perf_stalls_reg <= perf_stalls_reg + 32'd1;
    end
  end

  assign perf_reads  = perf_reads_reg;
  assign perf_writes = perf_writes_reg;
  assign perf_stalls = perf_stalls_reg;
`endif

  // Credits guarantee room, so a push into a full FIFO means the credit logic is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push_valid && fifo_full));
  a_req_known: assert property (@(posedge clk) disable iff (!reset)
    mem_req_valid |-> !$isunknown({mem_req_rw, mem_req_addr, mem_req_tag}));
  a_wr_known: assert property (@(posedge clk) disable iff (!reset)
    (mem_req_valid && mem_req_rw) |-> !$isunknown({mem_req_byteen, mem_req_data}));
  a_valid_held: assert property (@(posedge clk) disable iff (!reset)
    (mem_req_valid && !mem_req_ready) |=> mem_req_valid);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a randomized run against a
// line-memory model and an in-order expected-response queue.
module tb_mem_responder;
  localparam int LINE_SIZE      = 64;
  localparam int ADDR_WIDTH     = 26;
  localparam int RAM_ADDR_WIDTH = 10;
  localparam int TAG_WIDTH      = 8;
  localparam int LATENCY        = 4;
  localparam int RSP_QUEUE      = 8;
  localparam int DW             = LINE_SIZE * 8;
  localparam int N_RANDOM       = 10000;

  typedef struct {
    logic [TAG_WIDTH-1:0] tag;
    logic [DW-1:0]        data;
  } rsp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mem_req_valid;
  logic                  mem_req_rw;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [LINE_SIZE-1:0]  mem_req_byteen;
  logic [DW-1:0]         mem_req_data;
  logic [TAG_WIDTH-1:0]  mem_req_tag;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [DW-1:0]         mem_rsp_data;
  logic [TAG_WIDTH-1:0]  mem_rsp_tag;
  logic                  mem_rsp_ready;
  logic                  busy;
`ifdef MEM_RESPONDER_PERF_EN
  logic [31:0]           perf_reads;
  logic [31:0]           perf_writes;
  logic [31:0]           perf_stalls;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_reads    = 0;
  int exp_writes   = 0;
  int exp_stalls   = 0;
  logic [DW-1:0] ref_mem [1 << RAM_ADDR_WIDTH];

  always #5 clk = ~clk;

  mem_responder #(
    .LINE_SIZE(LINE_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
    .TAG_WIDTH(TAG_WIDTH), .LATENCY(LATENCY), .RSP_QUEUE(RSP_QUEUE)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_byteen(mem_req_byteen), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready), .busy(busy)
`ifdef MEM_RESPONDER_PERF_EN
    , .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls)
`endif
  );

  function automatic logic [DW-1:0] fill_line(input logic [7:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < LINE_SIZE; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] merge_line(input logic [DW-1:0] old_line,
                                               input logic [DW-1:0] new_line,
                                               input logic [LINE_SIZE-1:0] be);
    logic [DW-1:0] r;
    r = old_line;
    for (int i = 0; i < LINE_SIZE; i++) if (be[i]) r[i*8 +: 8] = new_line[i*8 +: 8];
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic send_req(input logic rw, input logic [ADDR_WIDTH-1:0] addr,
                          input logic [LINE_SIZE-1:0] be, input logic [DW-1:0] data,
                          input logic [TAG_WIDTH-1:0] tag, input bit verbose);
    int waited = 0;
    bit accepted = 0;
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = addr;
    mem_req_byteen = be; mem_req_data = data; mem_req_tag = tag;
    while (!accepted && waited < 100) begin
      @(negedge clk);
      if (mem_req_ready) accepted = 1; else exp_stalls++;
      @(posedge clk); #1;
      waited++;
    end
    mem_req_valid = 1'b0;
    tests_run++;
    if (!accepted) begin
      tests_failed++;
      $display("FAIL req_accept addr=%h: ready never seen in %0d cycles, required within 100", addr, waited);
    end else if (rw) begin
      ref_mem[addr[RAM_ADDR_WIDTH-1:0]] = merge_line(ref_mem[addr[RAM_ADDR_WIDTH-1:0]], data, be);
      exp_writes++;
    end else begin
      exp_reads++;
    end
    if (verbose) $display("[TB] req rw=%0d addr=%h be=%h tag=%h", rw, addr, be, tag);
  endtask

  task automatic check_rsp(input string name, input logic [TAG_WIDTH-1:0] exp_tag,
                           input logic [DW-1:0] exp_data, input int exp_lat);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 50) begin
      @(negedge clk);
      k++;
      if (mem_rsp_valid) seen = 1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s_timeout: rsp_valid=0 after %0d cycles, required 1", name, k);
      @(posedge clk); #1;
      return;
    end
    $display("[TB] rsp %s tag=%h after %0d cycles", name, mem_rsp_tag, k);
    if (exp_lat > 0) begin
      tests_run++;
      if (k !== exp_lat) begin
        tests_failed++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, k, exp_lat);
      end
    end
    tests_run++;
    if (mem_rsp_tag !== exp_tag) begin
      tests_failed++;
      $display("FAIL %s_tag: got %h, required %h", name, mem_rsp_tag, exp_tag);
    end
    tests_run++;
    if (mem_rsp_data !== exp_data) begin
      tests_failed++;
      $display("FAIL %s_data: got %h, required %h", name, mem_rsp_data, exp_data);
    end
    mem_rsp_ready = 1'b1;
    @(posedge clk); #1;
    mem_rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_req_valid = 1'b0; mem_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_reads = 0; exp_writes = 0; exp_stalls = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_req_valid = 1'b0; mem_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({mem_req_ready, mem_rsp_valid, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready/rsp_valid/busy=%b, required 000", {mem_req_ready, mem_rsp_valid, busy});
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (mem_req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_ready0: ready=%b, required 0 before first released edge", mem_req_ready);
    end
    @(negedge clk);
    tests_run++;
    if ({mem_req_ready, mem_rsp_valid, busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_release_ready1: ready/rsp_valid/busy=%b, required 100", {mem_req_ready, mem_rsp_valid, busy});
    end
    $display("[TB] reset sequence done");
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send_req(1'b1, 26'h5, '1, fill_line(8'hA5), 8'h00, 1);
    send_req(1'b0, 26'h5, '0, '0, 8'h03, 1);
    check_rsp("basic", 8'h03, fill_line(8'hA5), LATENCY);
  endtask

  task automatic test_byteen();
    logic [DW-1:0] d, e;
    d = rand_line();
    d[7:0] = 8'h11;
    e = fill_line(8'hA5);
    e[7:0] = 8'h11;
    send_req(1'b1, 26'h5, 64'h1, d, 8'h00, 1);
    send_req(1'b0, 26'h5, '0, '0, 8'h44, 1);
    check_rsp("byteen", 8'h44, e, LATENCY);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    e = ref_mem[5];
    mem_rsp_ready = 1'b0;
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 26'h5; mem_req_tag = '0;
    for (int i = 0; i < RSP_QUEUE; i++) begin
      @(negedge clk);
      tests_run++;
      if (mem_req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_accept_%0d: ready=%b, required 1", i, mem_req_ready);
      end
      @(posedge clk); #1;
      $display("[TB] req rw=0 addr=%h tag=%h", mem_req_addr, mem_req_tag);
      mem_req_tag = TAG_WIDTH'(i + 1);
    end
    mem_req_valid = 1'b0;
    exp_reads += RSP_QUEUE;
    repeat (LATENCY + 2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({mem_req_ready, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL b2b_full: ready/busy=%b, required 01", {mem_req_ready, busy});
    end
    @(posedge clk); #1 mem_rsp_ready = 1'b1;
    for (int i = 0; i < RSP_QUEUE; i++) begin
      @(negedge clk);
      tests_run++;
      if (!mem_rsp_valid || mem_rsp_tag !== TAG_WIDTH'(i) || mem_rsp_data !== e) begin
        tests_failed++;
        $display("FAIL b2b_rsp_%0d: valid=%b tag=%h data=%h, required valid=1 tag=%h data=%h",
                 i, mem_rsp_valid, mem_rsp_tag, mem_rsp_data, TAG_WIDTH'(i), e);
      end
      $display("[TB] rsp b2b tag=%h", mem_rsp_tag);
      if (i < 2) begin
        tests_run++;
        if (mem_req_ready !== (i == 1)) begin
          tests_failed++;
          $display("FAIL b2b_ready_after_pop_%0d: ready=%b, required %0d", i, mem_req_ready, (i == 1));
        end
      end
      @(posedge clk);
    end
    #1 mem_rsp_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mem_rsp_valid, busy, mem_req_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL b2b_drained: rsp_valid/busy/ready=%b, required 001", {mem_rsp_valid, busy, mem_req_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alias();
    logic [DW-1:0] d;
    d = rand_line();
    send_req(1'b1, 26'h405, '1, d, 8'h00, 1);
    send_req(1'b0, 26'h005, '0, '0, 8'h5A, 1);
    check_rsp("alias", 8'h5A, d, LATENCY);
  endtask

  task automatic test_random();
    int   idx_tbl [16];
    rsp_t exp_q [$];
    rsp_t e;
    int   reqs = 0;
    int   cycles = 0;
    bit   acc, pop;
    logic [ADDR_WIDTH-1:0] a;
    do_reset();
    for (int j = 0; j < 16; j++) begin
      idx_tbl[j] = (j * 67 + 3) % (1 << RAM_ADDR_WIDTH);
      a = ADDR_WIDTH'($urandom);
      a[RAM_ADDR_WIDTH-1:0] = RAM_ADDR_WIDTH'(idx_tbl[j]);
      send_req(1'b1, a, '1, rand_line(), 8'h00, 0);
    end
    while (reqs < N_RANDOM && cycles < 60000) begin
      if (!mem_req_valid && $urandom_range(0, 3) != 0) begin
        a = ADDR_WIDTH'($urandom);
        a[RAM_ADDR_WIDTH-1:0] = RAM_ADDR_WIDTH'(idx_tbl[$urandom_range(0, 15)]);
        mem_req_valid = 1'b1; mem_req_rw = 1'($urandom_range(0, 1)); mem_req_addr = a;
        mem_req_byteen = {$urandom, $urandom}; mem_req_data = rand_line();
        mem_req_tag = TAG_WIDTH'($urandom);
      end
      mem_rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests_run++;
      if (mem_req_ready !== (exp_q.size() < RSP_QUEUE) || busy !== (exp_q.size() != 0)) begin
        tests_failed++;
        $display("FAIL rnd_credit: ready=%b busy=%b, required ready=%0d busy=%0d",
                 mem_req_ready, busy, exp_q.size() < RSP_QUEUE, exp_q.size() != 0);
      end
      acc = mem_req_valid && mem_req_ready;
      pop = mem_rsp_valid && mem_rsp_ready;
      if (mem_req_valid && !mem_req_ready) exp_stalls++;
      if (pop) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rnd_unexpected_rsp: tag=%h, required no response", mem_rsp_tag);
        end else begin
          e = exp_q.pop_front();
          if (mem_rsp_tag !== e.tag || mem_rsp_data !== e.data) begin
            tests_failed++;
            $display("FAIL rnd_rsp: tag=%h data=%h, required tag=%h data=%h", mem_rsp_tag, mem_rsp_data, e.tag, e.data);
          end
        end
      end
      if (acc) begin
        if (mem_req_rw) begin
          ref_mem[mem_req_addr[RAM_ADDR_WIDTH-1:0]] =
            merge_line(ref_mem[mem_req_addr[RAM_ADDR_WIDTH-1:0]], mem_req_data, mem_req_byteen);
          exp_writes++;
        end else begin
          e.tag = mem_req_tag;
          e.data = ref_mem[mem_req_addr[RAM_ADDR_WIDTH-1:0]];
          exp_q.push_back(e);
          exp_reads++;
        end
        reqs++;
      end
      @(posedge clk); #1;
      if (acc) mem_req_valid = 1'b0;
      cycles++;
    end
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b1;
    for (int c = 0; c < 200 && (exp_q.size() != 0 || busy); c++) begin
      @(negedge clk);
      if (mem_rsp_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rnd_unexpected_rsp: tag=%h, required no response", mem_rsp_tag);
        end else begin
          e = exp_q.pop_front();
          if (mem_rsp_tag !== e.tag || mem_rsp_data !== e.data) begin
            tests_failed++;
            $display("FAIL rnd_rsp: tag=%h data=%h, required tag=%h data=%h", mem_rsp_tag, mem_rsp_data, e.tag, e.data);
          end
        end
      end
      @(posedge clk); #1;
    end
    mem_rsp_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (reqs != N_RANDOM || exp_q.size() != 0 || mem_rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rnd_complete: reqs=%0d pending=%0d rsp_valid=%b busy=%b, required %0d 0 0 0",
               reqs, exp_q.size(), mem_rsp_valid, busy, N_RANDOM);
    end
    $display("[TB] random run: %0d requests, %0d reads, %0d writes, %0d stall cycles",
             reqs, exp_reads, exp_writes, exp_stalls);
`ifdef MEM_RESPONDER_PERF_EN
    tests_run++;
    if (perf_reads !== 32'(exp_reads) || perf_writes !== 32'(exp_writes) || perf_stalls !== 32'(exp_stalls)) begin
      tests_failed++;
      $display("FAIL perf_counters: reads=%0d writes=%0d stalls=%0d, required %0d %0d %0d",
               perf_reads, perf_writes, perf_stalls, exp_reads, exp_writes, exp_stalls);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] d;
    int spurious = 0;
    d = rand_line();
    send_req(1'b1, 26'h7, '1, d, 8'h00, 1);
    mem_rsp_ready = 1'b0;
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 26'h7; mem_req_tag = 8'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (mem_req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL mid_accept_%0d: ready=%b, required 1", i, mem_req_ready);
      end
      @(posedge clk); #1;
      $display("[TB] req rw=0 addr=%h tag=%h", mem_req_addr, mem_req_tag);
      mem_req_tag = mem_req_tag + 8'h1;
    end
    mem_req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, mem_rsp_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL mid_inflight: busy/rsp_valid=%b, required 10", {busy, mem_rsp_valid});
    end
    @(negedge clk);
    tests_run++;
    if ({mem_rsp_valid, busy, mem_req_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL mid_reset_clear: rsp_valid/busy/ready=%b, required 000", {mem_rsp_valid, busy, mem_req_ready});
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 mem_rsp_ready = 1'b1;
    repeat (LATENCY + 4) begin
      @(negedge clk);
      if (mem_rsp_valid || busy) spurious++;
    end
    tests_run++;
    if (spurious != 0) begin
      tests_failed++;
      $display("FAIL mid_discard: %0d cycles with rsp_valid or busy, required 0", spurious);
    end
    @(posedge clk); #1 mem_rsp_ready = 1'b0;
    send_req(1'b0, 26'h7, '0, '0, 8'h77, 1);
    check_rsp("post_reset", 8'h77, d, LATENCY);
  endtask

  initial begin
    reset = 1'b0; mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0;
    mem_req_byteen = '0; mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_byteen();
    test_back_to_back();
    test_alias();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded 200000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
